// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise the CPU has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              pick_dbg;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    always_comb begin
        pick_dbg = 1'b0;
        if (dbg_req_i && !cpu_req_i) begin
            pick_dbg = 1'b1;
        end else if (dbg_req_i && cpu_req_i) begin
`ifdef DMEM_ARB_RR_EN
            pick_dbg = ~last_grant;
`else
            // fixed priority: history is tracked but never consulted
            pick_dbg = last_grant & 1'b0;
`endif
        end
        we_sel    = pick_dbg ? dbg_we_i    : cpu_we_i;
        addr_sel  = pick_dbg ? dbg_addr_i  : cpu_addr_i;
        wdata_sel = pick_dbg ? dbg_wdata_i : cpu_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            grant_o     <= '0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            cpu_ack_o   <= 1'b0;
            dbg_ack_o   <= 1'b0;
            cpu_rdata_o <= '0;
            dbg_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i || dbg_req_i) begin
                        lat_we      <= we_sel;
                        lat_addr    <= addr_sel;
                        lat_wdata   <= wdata_sel;
                        grant_o     <= pick_dbg ? 2'b10 : 2'b01;
                        last_grant  <= pick_dbg;
                        cnt         <= CNT_INIT;
                        mem_read_o  <= ~we_sel;
                        // single-cycle access: the write strobe belongs to the first ACCESS cycle
                        mem_write_o <= we_sel && (MEM_LAT == 1);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_read_o  <= 1'b0;
                        mem_write_o <= 1'b0;
                        if (!lat_we) begin
                            if (grant_o[1]) dbg_rdata_o <= mem_rdata_i;
                            else            cpu_rdata_o <= mem_rdata_i;
                        end
                        if (grant_o[1]) dbg_ack_o <= 1'b1;
                        else            cpu_ack_o <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt         <= cnt - 4'd1;
                        mem_write_o <= lat_we && (cnt == 4'd1);
                    end
                end
                DONE: begin
                    cpu_ack_o <= 1'b0;
                    dbg_ack_o <= 1'b0;
                    grant_o   <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;
    assign busy_o      = (state != IDLE);
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3)
// checked cycle by cycle against a transaction-level timing model.
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_ack   [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_wdata [2];
    logic [31:0] dbg_rdata [2];
    logic        dbg_ack   [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  grant     [2];
    logic        busy      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .cpu_req_i(cpu_req[g]), .cpu_we_i(cpu_we[g]), .cpu_addr_i(cpu_addr[g]),
            .cpu_wdata_i(cpu_wdata[g]), .cpu_rdata_o(cpu_rdata[g]), .cpu_ack_o(cpu_ack[g]),
            .cpu_stall_o(cpu_stall[g]),
            .dbg_req_i(dbg_req[g]), .dbg_we_i(dbg_we[g]), .dbg_addr_i(dbg_addr[g]),
            .dbg_wdata_i(dbg_wdata[g]), .dbg_rdata_o(dbg_rdata[g]), .dbg_ack_o(dbg_ack[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_read_o(mem_read[g]),
            .mem_write_o(mem_write[g]), .mem_rdata_i(mem_rdata[g]),
            .grant_o(grant[g]), .busy_o(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cur_d = 0;
    logic [31:0] exp_crd  [2];
    logic [31:0] exp_drd  [2];
    logic        exp_last [2];   // 1 = debug was granted last

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %0h, expected %0h", cur_d, tag, got, exp);
        end
    endtask

    task automatic check_outputs(input int d, input logic e_busy, input logic [1:0] e_grant,
                                 input logic e_rd, input logic e_wr, input logic chk_bus,
                                 input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                 input logic e_cack, input logic e_dack);
        cur_d = d;
        chk("busy", 32'(busy[d]), 32'(e_busy));
        chk("grant", 32'(grant[d]), 32'(e_grant));
        chk("mem_read", 32'(mem_read[d]), 32'(e_rd));
        chk("mem_write", 32'(mem_write[d]), 32'(e_wr));
        chk("cpu_ack", 32'(cpu_ack[d]), 32'(e_cack));
        chk("dbg_ack", 32'(dbg_ack[d]), 32'(e_dack));
        chk("cpu_rdata", cpu_rdata[d], exp_crd[d]);
        chk("dbg_rdata", dbg_rdata[d], exp_drd[d]);
        chk("cpu_stall", 32'(cpu_stall[d]), 32'(cpu_req[d] & ~e_cack));
        if (chk_bus) begin
            chk("mem_addr", mem_addr[d], e_addr);
            chk("mem_wdata", mem_wdata[d], e_wdata);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_crd[i]  = '0;
            exp_drd[i]  = '0;
            exp_last[i] = 1'b1;
        end
    endtask

    task automatic new_cpu(input int d);
        cpu_req[d]   = 1'b1;
        cpu_we[d]    = 1'($urandom_range(0, 1));
        cpu_addr[d]  = $urandom;
        cpu_wdata[d] = $urandom;
    endtask

    task automatic new_dbg(input int d);
        dbg_req[d]   = 1'b1;
        dbg_we[d]    = 1'($urandom_range(0, 1));
        dbg_addr[d]  = $urandom;
        dbg_wdata[d] = $urandom;
    endtask

    // Entered and left at a falling edge while the DUT is idle.
    task automatic run_random(input int d, input int n_txn);
        int          lat;
        logic        cp, dp, w_dbg, lwe;
        logic [31:0] laddr, lwd, lrd;
        lat = (d == 0) ? 1 : 3;
        cp = 1'b0;
        dp = 1'b0;
        lrd = '0;
        for (int t = 0; t < n_txn; ) begin
            if (!cp && !dp) begin
                if ($urandom_range(0, 5) == 0) begin
                    check_outputs(d, 0, 2'b00, 0, 0, 0, '0, '0, 0, 0);
                    @(posedge clk);
                    @(negedge clk);
                    continue;
                end
                cp = 1'($urandom_range(0, 1));
                dp = 1'($urandom_range(0, 1));
                if (!cp && !dp) begin
                    if ($urandom_range(0, 1) == 1) cp = 1'b1;
                    else dp = 1'b1;
                end
                if (cp) new_cpu(d);
                if (dp) new_dbg(d);
            end
            #1;
            check_outputs(d, 0, 2'b00, 0, 0, 0, '0, '0, 0, 0);
`ifdef DMEM_ARB_RR_EN
            w_dbg = dp && (!cp || !exp_last[d]);
`else
            w_dbg = dp && !cp;
`endif
            exp_last[d] = w_dbg;
            lwe   = w_dbg ? dbg_we[d]    : cpu_we[d];
            laddr = w_dbg ? dbg_addr[d]  : cpu_addr[d];
            lwd   = w_dbg ? dbg_wdata[d] : cpu_wdata[d];
            @(posedge clk);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                check_outputs(d, 1, w_dbg ? 2'b10 : 2'b01, !lwe, lwe && (k == lat), 1,
                              laddr, lwd, 0, 0);
                mem_rdata[d] = $urandom;
                lrd = mem_rdata[d];
                // the winner may drop or scramble its inputs once latched
                if ($urandom_range(0, 3) == 0) begin
                    if (w_dbg) begin
                        dbg_req[d] = 1'($urandom_range(0, 1));
                        dbg_we[d] = 1'($urandom_range(0, 1));
                        dbg_addr[d] = $urandom;
                        dbg_wdata[d] = $urandom;
                        dp = dbg_req[d];
                    end else begin
                        cpu_req[d] = 1'($urandom_range(0, 1));
                        cpu_we[d] = 1'($urandom_range(0, 1));
                        cpu_addr[d] = $urandom;
                        cpu_wdata[d] = $urandom;
                        cp = cpu_req[d];
                    end
                end
                @(posedge clk);
            end
            @(negedge clk);
            if (!lwe) begin
                if (w_dbg) exp_drd[d] = lrd;
                else exp_crd[d] = lrd;
            end
            check_outputs(d, 1, w_dbg ? 2'b10 : 2'b01, 0, 0, 0, '0, '0, !w_dbg, w_dbg);
            if (w_dbg) begin
                dp = ($urandom_range(0, 2) != 0);
                if (dp) new_dbg(d);
                else dbg_req[d] = 1'b0;
            end else begin
                cp = ($urandom_range(0, 2) != 0);
                if (cp) new_cpu(d);
                else cpu_req[d] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        cpu_req[d] = 1'b0;
        dbg_req[d] = 1'b0;
    endtask

    // CPU write on the MEM_LAT=3 instance, reset during the second ACCESS cycle.
    task automatic reset_mid_access();
        new_cpu(1);
        cpu_we[1] = 1'b1;
        #1;
        check_outputs(1, 0, 2'b00, 0, 0, 0, '0, '0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_outputs(1, 1, 2'b01, 0, 0, 1, cpu_addr[1], cpu_wdata[1], 0, 0);
        @(posedge clk);
        @(negedge clk);
        check_outputs(1, 1, 2'b01, 0, 0, 1, cpu_addr[1], cpu_wdata[1], 0, 0);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check_outputs(1, 0, 2'b00, 0, 0, 1, '0, '0, 0, 0);
        rst = 1'b0;
        cpu_req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs(1, 0, 2'b00, 0, 0, 1, '0, '0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
            mem_rdata[i] = '0;
        end
        model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                new_cpu(i);
                new_dbg(i);
                cpu_req[i] = 1'($urandom_range(0, 1));
                dbg_req[i] = 1'($urandom_range(0, 1));
                mem_rdata[i] = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1'b0;
            dbg_req[i] = 1'b0;
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check_outputs(i, 0, 2'b00, 0, 0, 1, '0, '0, 0, 0);
        @(negedge clk);

        run_random(0, 80);
        run_random(1, 80);
        reset_mid_access();
        run_random(1, 40);
        run_random(0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
